// File: rtl/bus_slave_port_if.sv
// Bit-serial system bus as seen by one slave slot: arbiter-side controls in,
// serial read data and completion status out.
interface bus_slave_port_if;
    logic       select;
    logic       write;
    logic       addr;
    logic       wdata;
    logic       rdata;
    logic       rvalid;
    logic       ready;
    logic [1:0] resp;

    modport master (
        output select, write, addr, wdata,
        input  rdata, rvalid, ready, resp
    );

    modport slave (
        input  select, write, addr, wdata,
        output rdata, rvalid, ready, resp
    );
endinterface

// File: rtl/bus_slave_port.sv
// Slave endpoint of the bit-serial bus: serial address/data in, local register
// memory, serial read-back, and a one-cycle ready/resp completion.
module bus_slave_port #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input logic             clk,
    input logic             reset_n,
    bus_slave_port_if.slave bus
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_FETCH = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
    logic [DATA_W-1:0] data_sh_q, data_sh_d;
    logic              write_q, write_d;
    logic              rvalid_q, rvalid_d;
    logic              ready_q, ready_d;
    logic [1:0]        resp_q, resp_d;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic [ADDR_W-1:0] addr_shifted;
    logic [DATA_W-1:0] data_shifted;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              mem_we;
    logic [DATA_W-1:0] rd_word;

    assign addr_shifted = (addr_sh_q << 1) | ADDR_W'(bus.addr);
    assign data_shifted = (data_sh_q << 1) | DATA_W'(bus.wdata);
    assign idx          = addr_sh_q[IDX_W-1:0];
    assign in_range     = ({1'b0, addr_sh_q} < DEPTH_LIM);
    assign rd_word      = in_range ? mem_q[idx] : '0;

    // Write only on the final wdata edge of an uninterrupted, in-range transfer
    assign mem_we = reset_n && bus.select && (state_q == S_WDATA) &&
                    (cnt_q == DATA_LAST) && in_range;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_sh_d = addr_sh_q;
        data_sh_d = data_sh_q;
        write_d   = write_q;

        case (state_q)
            S_IDLE: begin
                if (bus.select) begin
                    write_d   = bus.write;
                    addr_sh_d = '0;
                    cnt_d     = '0;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (!bus.select) begin
                    state_d = S_IDLE;
                end else begin
                    addr_sh_d = addr_shifted;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d     = '0;
                        data_sh_d = '0;
                        state_d   = write_q ? S_WDATA : S_FETCH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WDATA: begin
                if (!bus.select) begin
                    state_d = S_IDLE;
                end else begin
                    data_sh_d = data_shifted;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (!bus.select) begin
                    state_d = S_IDLE;
                end else begin
                    data_sh_d = rd_word;
                    cnt_d     = '0;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                // rdata presents the shift-register MSB, so shift after each bit
                if (!bus.select) begin
                    state_d = S_IDLE;
                end else begin
                    data_sh_d = data_sh_q << 1;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rvalid_d = (state_d == S_RDATA);
        ready_d  = (state_d == S_DONE);
        resp_d   = resp_q;
        if (state_d == S_DONE) begin
            resp_d = in_range ? RESP_OKAY : RESP_ERROR;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_sh_q <= '0;
            data_sh_q <= '0;
            write_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            ready_q   <= 1'b0;
            resp_q    <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_sh_q <= addr_sh_d;
            data_sh_q <= data_sh_d;
            write_q   <= write_d;
            rvalid_q  <= rvalid_d;
            ready_q   <= ready_d;
            resp_q    <= resp_d;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= data_shifted;
        end
    end

    assign bus.rdata  = rvalid_q & data_sh_q[DATA_W-1];
    assign bus.rvalid = rvalid_q;
    assign bus.ready  = ready_q;
    assign bus.resp   = resp_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// Scoreboard bench for bus_slave_port: full-depth and 128-word instances,
// directed transactions with hand-computed serial read bits and responses.
module tb_bus_slave_port;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b01;
    localparam int FULL = 99;

    typedef struct { int cyc; logic b; }       rbit_t;
    typedef struct { int cyc; logic [1:0] r; } rdy_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sel = 1'b0, wr = 1'b0, ad = 1'b0, wd = 1'b0;
    logic tgt = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    rbit_t rbq[$];
    rdy_t  rdyq[$];

    bus_slave_port_if bus0 ();
    bus_slave_port_if bus1 ();

    assign bus0.select = sel & ~tgt;
    assign bus1.select = sel & tgt;
    assign bus0.write  = wr;
    assign bus1.write  = wr;
    assign bus0.addr   = ad;
    assign bus1.addr   = ad;
    assign bus0.wdata  = wd;
    assign bus1.wdata  = wd;

    bus_slave_port #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(256)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );

    bus_slave_port #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(128)) dut128 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    logic       m_rdata, m_rvalid, m_ready;
    logic [1:0] m_resp;
    assign m_rdata  = tgt ? bus1.rdata  : bus0.rdata;
    assign m_rvalid = tgt ? bus1.rvalid : bus0.rvalid;
    assign m_ready  = tgt ? bus1.ready  : bus0.ready;
    assign m_resp   = tgt ? bus1.resp   : bus0.resp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic flag(input string nm);
        total++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the selected slave shows rvalid/ready
    always @(negedge clk) begin
        rbit_t eb;
        rdy_t  er;
        while (rbq.size() > 0 && rbq[0].cyc < cyc) begin
            flag("rvalid_missing");
            void'(rbq.pop_front());
        end
        while (rdyq.size() > 0 && rdyq[0].cyc < cyc) begin
            flag("ready_missing");
            void'(rdyq.pop_front());
        end
        if (m_rvalid) begin
            if (rbq.size() == 0) flag("rvalid_unexpected");
            else begin
                eb = rbq.pop_front();
                chk("rvalid_cycle", cyc, eb.cyc);
                chk("rdata_bit", 32'(m_rdata), 32'(eb.b));
            end
        end
        if (m_ready) begin
            if (rdyq.size() == 0) flag("ready_unexpected");
            else begin
                er = rdyq.pop_front();
                chk("ready_cycle", cyc, er.cyc);
                chk("resp", 32'(m_resp), 32'(er.r));
            end
        end
    end

    task automatic abort(input logic by_rst);
        if (by_rst) reset_n = 1'b0;
        else sel = 1'b0;
        tick();
        reset_n = 1'b1;
        sel = 1'b0;
        chk("abort_rvalid", 32'(m_rvalid), 32'd0);
        chk("abort_ready", 32'(m_ready), 32'd0);
        if (by_rst) chk("reset_resp", 32'(m_resp), 32'd0);
    endtask

    // cut = number of data bits before select drops (or reset); FULL = no abort
    task automatic run(input logic t, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic [1:0] er,
                       input logic [7:0] ew, input int cut,
                       input logic by_rst, input logic keep);
        int s;
        tgt = t;
        wr  = w;
        sel = 1'b1;
        ad  = 1'b0;
        wd  = 1'b0;
        tick();
        s = cyc;
        if (w && cut >= 8) rdyq.push_back('{s + 16, er});
        if (!w) begin
            for (int i = 0; i < 8 && i <= cut; i++) rbq.push_back('{s + 9 + i, ew[7-i]});
            if (cut >= 8) rdyq.push_back('{s + 17, er});
        end
        for (int i = 0; i < 8; i++) begin
            ad = a[7-i];
            tick();
        end
        if (!w) tick();
        for (int i = 0; i < 8; i++) begin
            if (i == cut) begin
                abort(by_rst);
                return;
            end
            if (w) wd = d[7-i];
            tick();
        end
        tick();
        if (!keep) sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_rvalid0", 32'(bus0.rvalid), 32'd0);
        chk("rst_ready0",  32'(bus0.ready),  32'd0);
        chk("rst_resp0",   32'(bus0.resp),   32'd0);
        chk("rst_rdata0",  32'(bus0.rdata),  32'd0);
        chk("rst_rvalid1", 32'(bus1.rvalid), 32'd0);
        chk("rst_ready1",  32'(bus1.ready),  32'd0);
        chk("rst_resp1",   32'(bus1.resp),   32'd0);
        reset_n = 1'b1;
        tick();

        // Basic write then read-back of 0xA5 (0x3C -> 0,0,1,1,1,1,0,0)
        run(1'b0, 1'b1, 8'hA5, 8'h3C, OK, 8'h00, FULL, 1'b0, 1'b0);
        tick();
        run(1'b0, 1'b0, 8'hA5, 8'h00, OK, 8'h3C, FULL, 1'b0, 1'b0);
        tick();

        // 128-word instance: last valid word, then out-of-range write/read
        run(1'b1, 1'b1, 8'h00, 8'h5A, OK, 8'h00, FULL, 1'b0, 1'b0);
        run(1'b1, 1'b1, 8'h7F, 8'h81, OK, 8'h00, FULL, 1'b0, 1'b0);
        run(1'b1, 1'b1, 8'h80, 8'hFF, ERR, 8'h00, FULL, 1'b0, 1'b0);
        tick();
        chk("resp_held_err", 32'(m_resp), 32'(ERR));
        run(1'b1, 1'b0, 8'h80, 8'h00, ERR, 8'h00, FULL, 1'b0, 1'b0);
        run(1'b1, 1'b0, 8'h00, 8'h00, OK, 8'h5A, FULL, 1'b0, 1'b0);
        run(1'b1, 1'b0, 8'h7F, 8'h00, OK, 8'h81, FULL, 1'b0, 1'b0);
        tick();

        // Abort after 3 wdata bits leaves old contents intact
        run(1'b0, 1'b1, 8'h10, 8'h77, OK, 8'h00, FULL, 1'b0, 1'b0);
        run(1'b0, 1'b1, 8'h10, 8'hAA, OK, 8'h00, 3, 1'b0, 1'b0);
        tick();
        run(1'b0, 1'b0, 8'h10, 8'h00, OK, 8'h77, FULL, 1'b0, 1'b0);
        tick();

        // Back-to-back write then read with select held high
        run(1'b0, 1'b1, 8'h42, 8'hC3, OK, 8'h00, FULL, 1'b0, 1'b1);
        run(1'b0, 1'b0, 8'h42, 8'h00, OK, 8'hC3, FULL, 1'b0, 1'b0);
        tick();

        // Reset pulse during read data, then normal transactions
        run(1'b0, 1'b0, 8'hA5, 8'h00, OK, 8'h3C, 2, 1'b1, 1'b0);
        run(1'b0, 1'b0, 8'hA5, 8'h00, OK, 8'h3C, FULL, 1'b0, 1'b0);
        run(1'b0, 1'b0, 8'h42, 8'h00, OK, 8'hC3, FULL, 1'b0, 1'b0);

        repeat (4) tick();
        chk("pending_rvalid", rbq.size(), 32'd0);
        chk("pending_ready", rdyq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
